// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: start detection, bit/edge counting,
// LSB-first deserialization, parity/stop checking and data_valid strobe.
module uart_rx_ctrl #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic [4:0]            prescale,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic                  sampled_bit,
   output logic                  dat_samp_en,
   output logic [2:0]            edge_cnt,
   output logic [3:0]            bit_cnt,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  data_valid,
   output logic                  par_err,
   output logic                  stp_err
);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t state;
   logic   p8;        // latched prescale: 1 = 8, 0 = 4
   logic   par_en_q;
   logic   par_typ_q;
   logic   last_edge;
   logic   legal_pre;

   assign last_edge = (edge_cnt == (p8 ? 3'd7 : 3'd3));
   assign legal_pre = (prescale == 5'd4) || (prescale == 5'd8);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state       <= IDLE;
         p8          <= 1'b0;
         par_en_q    <= 1'b0;
         par_typ_q   <= 1'b0;
         dat_samp_en <= 1'b0;
         edge_cnt    <= 3'd0;
         bit_cnt     <= 4'd0;
         P_DATA      <= '0;
         data_valid  <= 1'b0;
         par_err     <= 1'b0;
         stp_err     <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         if (state == IDLE) begin
            dat_samp_en <= 1'b0;
            edge_cnt    <= 3'd0;
            if (!RX_IN && legal_pre) begin
               state       <= START;
               dat_samp_en <= 1'b1;
               bit_cnt     <= 4'd0;
               p8          <= (prescale == 5'd8);
               par_en_q    <= PAR_EN;
               par_typ_q   <= PAR_TYP;
               par_err     <= 1'b0;
               stp_err     <= 1'b0;
            end
         end else begin
            edge_cnt <= last_edge ? 3'd0 : edge_cnt + 3'd1;
            if (last_edge) begin
               case (state)
                  START: begin
                     if (sampled_bit) begin
                        state       <= IDLE;
                        dat_samp_en <= 1'b0;
                     end else begin
                        state   <= DATA;
                        bit_cnt <= 4'd0;
                     end
                  end
                  DATA: begin
                     for (int i = 0; i < DATA_WIDTH; i++)
                        if (bit_cnt == 4'(i)) P_DATA[i] <= sampled_bit;
                     if (bit_cnt == 4'(DATA_WIDTH - 1)) begin
                        bit_cnt <= 4'd0;
                        state   <= par_en_q ? PARITY : STOP;
                     end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                     end
                  end
                  PARITY: begin
                     par_err <= (sampled_bit != ((^P_DATA) ^ par_typ_q));
                     state   <= STOP;
                  end
                  STOP: begin
                     stp_err     <= ~sampled_bit;
                     data_valid  <= ~par_err & sampled_bit;
                     dat_samp_en <= 1'b0;
                     state       <= IDLE;
                  end
                  default: state <= IDLE;
               endcase
            end
         end
      end
   end

endmodule
